// File: rtl/ram_arbiter.sv
// Arbiter sharing one external-RAM controller port between bootloader,
// CPU data port and CPU fetch, with anti-starvation and a watchdog.
module ram_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_done_in,
  input  logic        boot_req,
  input  logic [17:0] boot_addr,
  input  logic [15:0] boot_wdata,
  output logic        boot_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [17:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_done,
  input  logic        inst_req,
  input  logic [17:0] inst_addr,
  output logic        inst_done,
  output logic [15:0] rdata,
  output logic        ram_need_to_work,
  output logic        ram_we,
  output logic [17:0] ram_addr_out,
  output logic [15:0] ram_data_out,
  input  logic        ram_work_done,
  input  logic [15:0] ram_rdata,
  output logic        timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1) < 1 ? 1
                    : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [7:0] WLIM = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_BOOT,
    G_DATA,
    G_INST
  } grant_t;

  state_t        state_q, state_d;
  grant_t        grant_q, grant_d;
  grant_t        sel;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    wd_q, wd_d;
  logic          need_q, need_d;
  logic          we_q, we_d;
  logic [17:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          bdone_q, bdone_d;
  logic          ddone_q, ddone_d;
  logic          idone_q, idone_d;
  logic          tout_q, tout_d;
  logic          finish;

  // Boot phase admits only the bootloader; afterwards data beats
  // fetch unless fetch has waited through STARVE_LIMIT data grants.
  always_comb begin
    sel = G_NONE;
    if (!boot_done_in) begin
      if (boot_req) sel = G_BOOT;
    end else if (inst_req && (!data_req || starve_q == SLIM)) begin
      sel = G_INST;
    end else if (data_req) begin
      sel = G_DATA;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    wd_d     = wd_q;
    need_d   = need_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    bdone_d  = bdone_q;
    ddone_d  = ddone_q;
    idone_d  = idone_q;
    tout_d   = tout_q;
    finish   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sel != G_NONE) begin
          grant_d = sel;
          need_d  = 1'b1;
          wd_d    = '0;
          state_d = S_BUSY;
        end
        unique case (1'b1)
          (sel == G_BOOT): begin
            we_d    = 1'b1;
            addr_d  = boot_addr;
            wdata_d = boot_wdata;
          end
          (sel == G_DATA): begin
            we_d    = data_we;
            addr_d  = data_addr;
            wdata_d = data_wdata;
            if (inst_req && starve_q != SLIM)
              starve_d = starve_q + 1'b1;
          end
          (sel == G_INST): begin
            we_d     = 1'b0;
            addr_d   = inst_addr;
            wdata_d  = '0;
            starve_d = '0;
          end
          default: ;
        endcase
      end
      S_BUSY: begin
        if (ram_work_done) begin
          finish = 1'b1;
          if (!we_q) rdata_d = ram_rdata;
        end else if (wd_q == WLIM) begin
          finish = 1'b1;
          tout_d = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
        if (finish) begin
          need_d  = 1'b0;
          state_d = S_RESP;
          unique case (1'b1)
            (grant_q == G_BOOT): bdone_d = 1'b1;
            (grant_q == G_DATA): ddone_d = 1'b1;
            (grant_q == G_INST): idone_d = 1'b1;
            default: ;
          endcase
        end
      end
      S_RESP: begin
        bdone_d = 1'b0;
        ddone_d = 1'b0;
        idone_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        need_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= G_NONE;
      starve_q <= '0;
      wd_q     <= '0;
      need_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bdone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      idone_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      need_q   <= need_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      bdone_q  <= bdone_d;
      ddone_q  <= ddone_d;
      idone_q  <= idone_d;
      tout_q   <= tout_d;
    end
  end

  assign boot_done        = bdone_q;
  assign data_done        = ddone_q;
  assign inst_done        = idone_q;
  assign rdata            = rdata_q;
  assign ram_need_to_work = need_q;
  assign ram_we           = we_q;
  assign ram_addr_out     = addr_q;
  assign ram_data_out     = wdata_q;
  assign timeout_err      = tout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: RAM-side and completion-side
// expectation queues checked by a negedge monitor.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done_in;
  logic        boot_req;
  logic [17:0] boot_addr;
  logic [15:0] boot_wdata;
  logic        boot_done;
  logic        data_req;
  logic        data_we;
  logic [17:0] data_addr;
  logic [15:0] data_wdata;
  logic        data_done;
  logic        inst_req;
  logic [17:0] inst_addr;
  logic        inst_done;
  logic [15:0] rdata;
  logic        ram_need_to_work;
  logic        ram_we;
  logic [17:0] ram_addr_out;
  logic [15:0] ram_data_out;
  logic        ram_work_done;
  logic [15:0] ram_rdata;
  logic        timeout_err;

  ram_arbiter dut (
    .clk(clk), .rst(rst), .boot_done_in(boot_done_in),
    .boot_req(boot_req), .boot_addr(boot_addr),
    .boot_wdata(boot_wdata), .boot_done(boot_done),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_done(inst_done),
    .rdata(rdata), .ram_need_to_work(ram_need_to_work),
    .ram_we(ram_we), .ram_addr_out(ram_addr_out),
    .ram_data_out(ram_data_out), .ram_work_done(ram_work_done),
    .ram_rdata(ram_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic        we;
    logic [15:0] wdata;
  } ram_exp_t;

  typedef struct {
    logic [2:0]  who;
    logic        chk_rd;
    logic [15:0] rd;
    logic        to;
    int          dly;
  } done_exp_t;

  ram_exp_t  ram_q[$];
  done_exp_t done_q[$];
  ram_exp_t  cur;
  logic      cur_ok = 1'b0;
  logic      prev_need = 1'b0;
  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int        rise_cyc = 0;
  int        lat = 1;
  int        rcnt = 0;
  int        data_left = 1;
  int        inst_left = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ram_val(input logic [17:0] a);
    return (a == 18'h100) ? 16'hBEEF : a[15:0] + 16'h1000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push_ram(input logic [17:0] a, input logic w,
                          input logic [15:0] d);
    ram_exp_t e;
    e.addr = a; e.we = w; e.wdata = d;
    ram_q.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] who, input logic cr,
                           input logic [15:0] rd, input logic to,
                           input int dly);
    done_exp_t e;
    e.who = who; e.chk_rd = cr; e.rd = rd; e.to = to; e.dly = dly;
    done_q.push_back(e);
  endtask

  // RAM controller model: done after `lat` BUSY cycles, never if 0
  initial begin
    ram_work_done = 1'b0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (ram_need_to_work && !ram_work_done) begin
        rcnt++;
        if (lat != 0 && rcnt == lat) begin
          ram_work_done = 1'b1;
          ram_rdata = ram_val(ram_addr_out);
        end
      end else begin
        ram_work_done = 1'b0;
        rcnt = 0;
      end
    end
  end

  // Monitor: RAM-side request checks and completion checks
  initial forever begin
    @(negedge clk);
    if (ram_need_to_work) begin
      if (!prev_need) begin
        rise_cyc = cyc;
        cur_ok = (ram_q.size() != 0);
        if (cur_ok) cur = ram_q.pop_front();
        else chk("ram_unexpected_req", 1, 0);
      end
      if (cur_ok) begin
        chk("ram_addr", ram_addr_out, cur.addr);
        chk("ram_we", ram_we, cur.we);
        if (cur.we) chk("ram_wdata", ram_data_out, cur.wdata);
      end
    end
    prev_need = ram_need_to_work;
    if (boot_done || data_done || inst_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", {boot_done, data_done, inst_done}, 0);
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        chk("done_vec", {boot_done, data_done, inst_done}, e.who);
        chk("timeout_err", timeout_err, e.to);
        chk("latency", cyc - rise_cyc, e.dly);
        if (e.chk_rd) chk("rdata", rdata, e.rd);
      end
      if (data_done && data_left > 0) begin
        data_left--;
        if (data_left == 0) data_req = 1'b0;
      end
      if (inst_done && inst_left > 0) begin
        inst_left--;
        if (inst_left == 0) inst_req = 1'b0;
      end
    end
  end

  task automatic check_zero(input string nm);
    chk(nm, {boot_done, data_done, inst_done, rdata, ram_need_to_work,
             ram_we, ram_addr_out, ram_data_out, timeout_err}, 0);
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((done_q.size() != 0 || ram_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done_q.size() + ram_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    boot_done_in = 1'b0;
    boot_req = 1'b0; boot_addr = '0; boot_wdata = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    inst_req = 1'b0; inst_addr = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;

    // Boot phase: CPU requests held high but must not be served
    lat = 1;
    data_req = 1'b1; data_addr = 18'h100;
    inst_req = 1'b1; inst_addr = 18'h200;
    for (int a = 0; a <= 18'h21A; a++) begin
      int n;
      push_ram(18'(a), 1'b1, 16'(a) ^ 16'h5A5A);
      push_done(3'b100, 1'b0, '0, 1'b0, 1);
      boot_addr = 18'(a);
      boot_wdata = 16'(a) ^ 16'h5A5A;
      boot_req = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!boot_done && n < 20);
      if (!boot_done) begin
        chk("boot_timeout", 0, 1);
        break;
      end
    end
    boot_req = 1'b0;
    data_req = 1'b0;
    inst_req = 1'b0;
    boot_done_in = 1'b1;
    drain("boot_drain", 20);

    // Priority: data beats fetch on a simultaneous request
    lat = 2;
    push_ram(18'h100, 1'b0, '0);
    push_ram(18'h200, 1'b0, '0);
    push_done(3'b010, 1'b1, 16'hBEEF, 1'b0, 2);
    push_done(3'b001, 1'b1, 16'h1200, 1'b0, 2);
    data_left = 1; inst_left = 1;
    data_we = 1'b0; data_addr = 18'h100; data_req = 1'b1;
    inst_addr = 18'h200; inst_req = 1'b1;
    drain("prio_drain", 60);

    // Starvation: four data grants, then fetch is forced in
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      push_ram(18'h104, 1'b0, '0);
      push_done(3'b010, 1'b1, 16'h1104, 1'b0, 1);
    end
    push_ram(18'h200, 1'b0, '0);
    push_done(3'b001, 1'b1, 16'h1200, 1'b0, 1);
    for (int i = 0; i < 2; i++) begin
      push_ram(18'h104, 1'b0, '0);
      push_done(3'b010, 1'b1, 16'h1104, 1'b0, 1);
    end
    data_left = 6; inst_left = 1;
    data_addr = 18'h104; data_req = 1'b1; inst_req = 1'b1;
    drain("starve_drain", 100);

    // Watchdog: no RAM completion, abort after 255 BUSY cycles
    lat = 0;
    push_ram(18'h108, 1'b0, '0);
    push_done(3'b010, 1'b1, 16'h1104, 1'b1, 255);
    data_left = 1;
    data_addr = 18'h108; data_req = 1'b1;
    drain("wdog_drain", 400);
    chk("timeout_sticky", timeout_err, 1);
    lat = 1;
    push_ram(18'h20C, 1'b0, '0);
    push_done(3'b001, 1'b1, 16'h120C, 1'b1, 1);
    inst_left = 1;
    inst_addr = 18'h20C; inst_req = 1'b1;
    drain("post_wdog_drain", 40);

    // Reset during a BUSY data write
    lat = 0;
    push_ram(18'h0AA, 1'b1, 16'h7777);
    data_left = 1;
    data_we = 1'b1; data_addr = 18'h0AA; data_wdata = 16'h7777;
    data_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("busy_before_rst", ram_need_to_work, 1);
    rst = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
    check_zero("mid_busy_reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", ram_need_to_work, 0);

    // Write path at top of address space
    lat = 3;
    push_ram(18'h3FFFF, 1'b1, 16'h1234);
    push_done(3'b010, 1'b1, 16'h0000, 1'b0, 3);
    data_left = 1;
    data_we = 1'b1; data_addr = 18'h3FFFF; data_wdata = 16'h1234;
    data_req = 1'b1;
    drain("write_drain", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
